// File: rtl/booth_mult_r4_seq.sv
// booth_mult_r4_seq: sequential radix-4 Booth multiplier, one digit per clock
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       begin a multiply (accepted in IDLE or DONE, ignored while busy)
//   signed_mode 1 = two's-complement operands, 0 = unsigned; captured with start
//   md, mr      multiplicand / multiplier (N bits), captured with start
//   busy        high while digits are being retired
//   done        one-cycle pulse when product is updated
//   product     2N-bit result of the last completed multiply, held until the next
module booth_mult_r4_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   md,
  input  logic [N-1:0]   mr,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int D  = N/2 + 1;
  localparam int A  = 2*N + 4;
  localparam int CW = $clog2(D + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t                state;
  logic signed [N+1:0]   md_x;
  // Extended multiplier with the implicit zero appended below its LSB
  logic        [N+2:0]   mr_z;
  logic signed [A-1:0]   acc;
  logic        [CW-1:0]  cnt;
  logic        [2:0]     win;
  logic signed [A-1:0]   mdw;
  logic signed [A-1:0]   mag;
  logic signed [A-1:0]   pp;
  logic signed [A-1:0]   acc_nx;
  logic                  last;
  always_comb begin
    win    = 3'(mr_z >> {cnt, 1'b0});
    mdw    = A'(md_x);
    mag    = (win == 3'b011 || win == 3'b100) ? mdw <<< 1 :
             (win == 3'b000 || win == 3'b111) ? '0 : mdw;
    pp     = win[2] ? ~mag + A'(1) : mag;
    acc_nx = acc + (pp <<< {cnt, 1'b0});
    last   = cnt == CW'(D - 1);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      md_x    <= '0;
      mr_z    <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        CALC: begin
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= acc_nx[2*N-1:0];
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            md_x  <= signed_mode ? {{2{md[N-1]}}, md} : {2'b00, md};
            mr_z  <= {(signed_mode ? {2{mr[N-1]}} : 2'b00), mr, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
